// File: rtl/dma_burst_ctrl.sv
// Burst DMA responder: copies cmd_length device words to memory, BURST_LEN words per BR/BG tenure.
// One cycle from command to BR and from grant to write; stalls on BG=0 or missing mem_ack; commands accepted only while cmd_ready.
module dma_burst_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int BURST_LEN = 4,
  parameter int LEN_W     = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [LEN_W-1:0]     cmd_length,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  output logic [LEN_W-1:0]     dev_idx,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 dma_end
);

  localparam int BCNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_GAP,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [BCNT_W-1:0]    burst_q, burst_d;
  logic                 br_q, br_d;
  logic                 mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_data_q, mem_data_d;
  logic [LEN_W-1:0]     dev_idx_q, dev_idx_d;
  logic                 busy_q, busy_d;
  logic                 dma_end_q, dma_end_d;
  logic                 cmd_ready_q, cmd_ready_d;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    br_d        = br_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    busy_d      = busy_q;
    dma_end_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d      = cmd_addr;
          remaining_d = cmd_length;
          cnt_d       = '0;
          burst_d     = '0;
          busy_d      = 1'b1;
          if (cmd_length == '0) begin
            state_d   = S_DONE;
            dma_end_d = 1'b1;
            br_d      = 1'b0;
          end else begin
            state_d = S_REQ;
            br_d    = 1'b1;
          end
        end
      end

      // dev_idx already equals cnt here, so dev_data is the word to write.
      S_REQ, S_GAP: begin
        if (BG) begin
          state_d     = S_WRITE;
          mem_write_d = 1'b1;
          mem_addr_d  = base_q + WORD_SIZE'(cnt_q);
          mem_data_d  = dev_data;
        end
      end

      S_WRITE: begin
        if (mem_ack) begin
          mem_write_d = 1'b0;
          cnt_d       = cnt_q + LEN_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          burst_d     = burst_q + BCNT_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d   = S_DONE;
            br_d      = 1'b0;
            dma_end_d = 1'b1;
          end else if (burst_q == BCNT_W'(BURST_LEN - 1)) begin
            state_d = S_RELEASE;
            br_d    = 1'b0;
          end else begin
            state_d = S_GAP;
          end
        end
      end

      S_RELEASE: begin
        burst_d = '0;
        state_d = S_REQ;
        br_d    = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        br_d        = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    dev_idx_d   = cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      br_q        <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      dev_idx_q   <= '0;
      busy_q      <= 1'b0;
      dma_end_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      br_q        <= br_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      dev_idx_q   <= dev_idx_d;
      busy_q      <= busy_d;
      dma_end_q   <= dma_end_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign BR        = br_q;
  assign dev_idx   = dev_idx_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign dma_end   = dma_end_q;

endmodule
